// File: rtl/dsm_pkg.sv
// Shared widths, legal integer range, FSM states and the combined tune word
// used by the DSM retune sequencer.
package dsm_pkg;

   localparam int DSM_ACC_W = 16;
   localparam int DSM_INT_W = 4;

   localparam int DSM_INT_MIN = 3;
   localparam int DSM_INT_MAX = 11;

   typedef enum logic [1:0] {
      RST_HOLD = 2'd0,
      IDLE     = 2'd1,
      RAMP     = 2'd2,
      SETTLE   = 2'd3
   } state_t;

   typedef logic [DSM_INT_W+DSM_ACC_W-1:0] tune_word_t;

endpackage

// File: rtl/dsm_tune_ctrl_if.sv
// Tuning-request handshake between a requester (master) and the retune
// sequencer (slave).
interface dsm_tune_ctrl_if
   import dsm_pkg::*;
#(
   parameter int INT_W = DSM_INT_W,
   parameter int ACC_W = DSM_ACC_W
) ();

   logic             cfg_valid;
   logic             cfg_ready;
   logic [INT_W-1:0] cfg_int;
   logic [ACC_W-1:0] cfg_frac;

   modport master (
      output cfg_valid,
      output cfg_int,
      output cfg_frac,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_int,
      input  cfg_frac,
      output cfg_ready
   );

endinterface

// File: rtl/dsm_ramp_gen.sv
// Linear slew of the combined {int,frac} word towards a latched target,
// one STEP every DIV cycles while start is high.
module dsm_ramp_gen
   import dsm_pkg::*;
#(
   parameter int          ACC_W    = DSM_ACC_W,
   parameter int          INT_W    = DSM_INT_W,
   parameter int          INIT_INT = 3,
   parameter int unsigned STEP     = 32'h0100,
   parameter int          DIV      = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   start,
   input  logic [INT_W+ACC_W-1:0] tgt_in,
   output logic [INT_W+ACC_W-1:0] cur,
   output logic                   at_tgt
);

   localparam int W = INT_W + ACC_W;
   localparam logic [W-1:0] STEP_N   = W'(STEP);
   localparam logic [W:0]   STEP_W   = {1'b0, STEP_N};
   localparam logic [W-1:0] INIT_CUR = {INT_W'(INIT_INT), ACC_W'(0)};

   logic [W-1:0] tgt;
   logic [W-1:0] cur_next;
   logic [W:0]   diff;
   logic [W:0]   mag;
   logic         up;
   logic         close;
   logic         step_now;
   logic [7:0]   div;

   // W+1-bit difference: the top bit is the sign, so tgt<cur never wraps.
   assign diff     = {1'b0, tgt} - {1'b0, cur};
   assign up       = ~diff[W];
   assign mag      = up ? diff : (~diff + 1'b1);
   assign close    = (mag <= STEP_W);
   assign step_now = start && (div == 8'(DIV - 1));
   assign at_tgt   = step_now && close;

   always_comb begin
      cur_next = cur;
      if (close) begin
         cur_next = tgt;
      end else if (up) begin
         cur_next = cur + STEP_N;
      end else begin
         cur_next = cur - STEP_N;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt <= INIT_CUR;
         cur <= INIT_CUR;
         div <= '0;
      end else if (load) begin
         tgt <= tgt_in;
         div <= '0;
      end else if (start) begin
         if (step_now) begin
            div <= '0;
            cur <= cur_next;
         end else begin
            div <= div + 8'd1;
         end
      end
   end

endmodule

// File: rtl/dsm_tune_ctrl.sv
// Retune sequencer for the MASH 1-1-1 DSM core: accepts range-checked tuning
// words, slews the core inputs to them, and sequences the core reset.
module dsm_tune_ctrl
   import dsm_pkg::*;
#(
   parameter int          ACC_W      = DSM_ACC_W,
   parameter int          INT_W      = DSM_INT_W,
   parameter int          INIT_INT   = 3,
   parameter int unsigned STEP       = 32'h0100,
   parameter int          DIV        = 4,
   parameter int          SETTLE_CYC = 3,
   parameter int          RST_CYC    = 4
) (
   input  logic             clk,
   input  logic             rst,
   dsm_tune_ctrl_if.slave   cfg,
   output logic [INT_W-1:0] dsm_in_i,
   output logic [ACC_W-1:0] dsm_in_f,
   output logic             dsm_rst_n,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int W = INT_W + ACC_W;

   state_t       state;
   state_t       state_nx;
   logic [7:0]   cnt;
   logic [7:0]   cnt_nx;
   logic         done_nx;
   logic         err_nx;
   logic         load;
   logic         start;
   logic         at_tgt;
   logic         accept;
   logic         in_range;
   logic [W-1:0] req;
   logic [W-1:0] cur;

   assign req      = {cfg.cfg_int, cfg.cfg_frac};
   assign accept   = cfg.cfg_valid && (state == IDLE);
   assign in_range = (int'(cfg.cfg_int) >= DSM_INT_MIN) && (int'(cfg.cfg_int) <= DSM_INT_MAX);
   assign start    = (state == RAMP);

   dsm_ramp_gen #(
      .ACC_W    (ACC_W),
      .INT_W    (INT_W),
      .INIT_INT (INIT_INT),
      .STEP     (STEP),
      .DIV      (DIV)
   ) u_ramp (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .start  (start),
      .tgt_in (req),
      .cur    (cur),
      .at_tgt (at_tgt)
   );

   // at_tgt fires on the edge of the final update, so SETTLE starts counting
   // the same cycle the last value reaches the core.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      load     = 1'b0;
      case (state)
         RST_HOLD: begin
            if (cnt == 8'(RST_CYC - 1)) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         IDLE: begin
            if (accept) begin
               if (!in_range) begin
                  err_nx = 1'b1;
               end else begin
                  load     = 1'b1;
                  cnt_nx   = '0;
                  state_nx = (req == cur) ? SETTLE : RAMP;
               end
            end
         end
         RAMP: begin
            cnt_nx = '0;
            if (at_tgt) begin
               state_nx = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == 8'(SETTLE_CYC - 1)) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               done_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         default: begin
            state_nx = RST_HOLD;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RST_HOLD;
         cnt   <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         done  <= done_nx;
         err   <= err_nx;
      end
   end

   assign {dsm_in_i, dsm_in_f} = cur;
   assign dsm_rst_n            = (state != RST_HOLD);
   assign busy                 = (state != IDLE);
   assign cfg.cfg_ready        = (state == IDLE);

endmodule
